// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the instruction-memory loader.
package imem_loader_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int CNT_W  = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_e;

  // Byte address of a word slot; wraps modulo 2^32.
  function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] base,
                                                  input logic [CNT_W-1:0]  idx);
    return base + {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Control, byte-stream and memory-write-port signals of the loader.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  word_count;
  logic              byte_valid;
  logic [BYTE_W-1:0] byte_data;
  logic              byte_ready;
  logic              mem_write;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              fetch_enable;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    output start, abort, word_count, byte_valid, byte_data,
    input  byte_ready, mem_write, mem_addr, mem_wdata, fetch_enable, busy, done, error
  );

  modport slave (
    input  start, abort, word_count, byte_valid, byte_data,
    output byte_ready, mem_write, mem_addr, mem_wdata, fetch_enable, busy, done, error
  );

endinterface

// File: rtl/imem_byte_packer.sv
// Assembles four program bytes, most-significant first, into one instruction word.
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_full
);

  logic [WORD_W-1:0] word_q, word_d;
  logic [1:0]        cnt_q, cnt_d;

  // Next shift-register contents and byte position
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clr) begin
      word_d = {WORD_W{1'b0}};
      cnt_d  = 2'd0;
    end else if (shift_en) begin
      word_d = {word_q[WORD_W-BYTE_W-1:0], byte_in};
      cnt_d  = cnt_q + 2'd1;
    end else begin
      word_d = word_q;
      cnt_d  = cnt_q;
    end
  end

  // Shift register and byte counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q <= {WORD_W{1'b0}};
      cnt_q  <= 2'd0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word = word_q;
  // Three bytes held: the next accepted byte completes the word.
  assign word_full = (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams program bytes into instruction memory, then releases the fetch stage.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [WORD_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned       MAX_WORDS = 1024
) (
  input logic          clk,
  input logic          rst,
  imem_loader_if.slave bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  word_idx_q, word_idx_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  next_idx_s;
  logic              bad_count_s;
  logic              pk_clr_s;
  logic              pk_shift_s;
  logic              pk_full_s;
  logic [WORD_W-1:0] pk_word_s;
  logic              wr_s;

  imem_byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (pk_clr_s),
    .shift_en  (pk_shift_s),
    .byte_in   (bus.byte_data),
    .word      (pk_word_s),
    .word_full (pk_full_s)
  );

  assign next_idx_s  = word_idx_q + 16'd1;
  assign bad_count_s = (bus.word_count == 16'd0) || ({16'd0, bus.word_count} > MAX_WORDS);

  // Next-state, counter and packer control
  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    count_d    = count_q;
    pk_clr_s   = 1'b0;
    pk_shift_s = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (bus.start) begin
          if (bad_count_s) begin
            state_d = ERR;
          end else begin
            state_d    = LOAD;
            count_d    = bus.word_count;
            word_idx_d = {CNT_W{1'b0}};
            pk_clr_s   = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      LOAD: begin
        if (bus.abort) begin
          state_d  = IDLE;
          pk_clr_s = 1'b1;
        end else begin
          pk_shift_s = bus.byte_valid;
          if (bus.byte_valid && pk_full_s) begin
            state_d = WRITE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      WRITE: begin
        // Abort wins over the strobe: the assembled word is dropped.
        if (bus.abort) begin
          state_d  = IDLE;
          pk_clr_s = 1'b1;
        end else begin
          word_idx_d = next_idx_s;
          if (next_idx_s == count_q) begin
            state_d = DONE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and word counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      word_idx_q <= {CNT_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      count_q    <= count_d;
    end
  end

  assign wr_s              = (state_q == WRITE) && !bus.abort;
  assign bus.mem_write     = wr_s;
  assign bus.mem_addr      = wr_s ? word_addr(BASE_ADDR, word_idx_q) : {WORD_W{1'b0}};
  assign bus.mem_wdata     = wr_s ? pk_word_s : {WORD_W{1'b0}};
  assign bus.byte_ready    = (state_q == LOAD);
  assign bus.fetch_enable  = (state_q == DONE);
  assign bus.busy          = (state_q == LOAD) || (state_q == WRITE);
  assign bus.done          = (state_q == DONE);
  assign bus.error         = (state_q == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader against a word-list reference model.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic start_r, abort_r, bv_r;
  logic [15:0] wc_r;
  logic [7:0]  bd_r;
  bit use1;

  int checks = 0;
  int failures = 0;

  wr_t obs0[$];
  wr_t obs1[$];
  logic [7:0] sent[$];
  logic [7:0] pat[$];

  imem_loader_if bus ();
  imem_loader_if bus1 ();

  assign bus.start       = start_r & ~use1;
  assign bus1.start      = start_r & use1;
  assign bus.abort       = abort_r;
  assign bus1.abort      = abort_r;
  assign bus.word_count  = wc_r;
  assign bus1.word_count = wc_r;
  assign bus.byte_valid  = bv_r;
  assign bus1.byte_valid = bv_r;
  assign bus.byte_data   = bd_r;
  assign bus1.byte_data  = bd_r;

  imem_loader dut0 (.clk(clk), .rst(rst), .bus(bus));
  imem_loader #(.BASE_ADDR(BASE1), .MAX_WORDS(1024)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  logic s_ready, s_write, s_fetch, s_busy, s_done, s_error;
  logic [5:0] s_ctl, ctl0, ctl1;
  assign s_ready = use1 ? bus1.byte_ready   : bus.byte_ready;
  assign s_write = use1 ? bus1.mem_write    : bus.mem_write;
  assign s_fetch = use1 ? bus1.fetch_enable : bus.fetch_enable;
  assign s_busy  = use1 ? bus1.busy         : bus.busy;
  assign s_done  = use1 ? bus1.done         : bus.done;
  assign s_error = use1 ? bus1.error        : bus.error;
  assign s_ctl = {s_ready, s_write, s_fetch, s_busy, s_done, s_error};
  assign ctl0  = {bus.byte_ready, bus.mem_write, bus.fetch_enable, bus.busy, bus.done, bus.error};
  assign ctl1  = {bus1.byte_ready, bus1.mem_write, bus1.fetch_enable, bus1.busy, bus1.done, bus1.error};

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Record every write strobe; the bus must read zero between writes.
  always @(negedge clk) begin
    if (bus.mem_write) begin
      obs0.push_back('{a: bus.mem_addr, d: bus.mem_wdata});
      chk("wr_ready_low0", 64'(bus.byte_ready), 64'd0);
    end else begin
      chk("idle_bus0", {bus.mem_addr, bus.mem_wdata}, 64'd0);
    end
    if (bus1.mem_write) begin
      obs1.push_back('{a: bus1.mem_addr, d: bus1.mem_wdata});
      chk("wr_ready_low1", 64'(bus1.byte_ready), 64'd0);
    end else begin
      chk("idle_bus1", {bus1.mem_addr, bus1.mem_wdata}, 64'd0);
    end
  end

  task automatic do_start(input logic [15:0] wc);
    @(posedge clk); #1;
    start_r = 1'b1;
    wc_r    = wc;
    @(posedge clk); #1;
    start_r = 1'b0;
  endtask

  // Offer one byte and hold it until the handshake completes.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      bv_r = 1'b0;
      @(posedge clk); #1;
    end
    bv_r = 1'b1;
    bd_r = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_ready && n < 64);
    if (!s_ready) chk("byte_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
  endtask

  // Model: word i = bytes 4i..4i+3 MSB first, at base + 4*i.
  task automatic check_writes(input int nexp, input logic [31:0] base);
    logic [31:0] ea, ed;
    int nobs;
    nobs = use1 ? obs1.size() : obs0.size();
    chk("wr_count", 64'(nobs), 64'(nexp));
    for (int i = 0; i < nexp && i < nobs; i++) begin
      ea = base + 32'(4 * i);
      ed = {sent[4*i], sent[4*i+1], sent[4*i+2], sent[4*i+3]};
      chk("wr_addr", 64'(use1 ? obs1[i].a : obs0[i].a), 64'(ea));
      chk("wr_data", 64'(use1 ? obs1[i].d : obs0[i].d), 64'(ed));
    end
    chk("other_quiet", 64'(use1 ? obs0.size() : obs1.size()), 64'd0);
    obs0.delete();
    obs1.delete();
  endtask

  // One load; abort_k >= 0 aborts right after that many bytes were accepted.
  task automatic run_load(input int wc, input int gapmode, input int abort_k, input bit sel);
    int nb, nexp;
    logic [7:0] b;
    bit gap;
    use1 = sel;
    sent.delete();
    do_start(16'(wc));
    chk("load_entry", 64'({s_fetch, s_busy, s_done}), 64'(3'b010));
    nb = (abort_k >= 0) ? abort_k : 4 * wc;
    for (int k = 0; k < nb; k++) begin
      b = (k < pat.size()) ? pat[k] : 8'($urandom);
      if (gapmode == 1)      gap = 1'b1;
      else if (gapmode == 2) gap = 1'($urandom_range(0, 1));
      else                   gap = 1'b0;
      send_byte(b, gap);
      sent.push_back(b);
      if ((k % 4 == 3) && !(abort_k >= 0 && k == nb - 1)) begin
        @(negedge clk);
        chk("wr_strobe", 64'(s_write), 64'd1);
        if (abort_k < 0 && k == nb - 1) begin
          bv_r = 1'b0;
          @(negedge clk);
          chk("done_flags", 64'({s_done, s_fetch, s_busy}), 64'(3'b110));
        end
      end
    end
    if (abort_k >= 0) begin
      bv_r    = 1'b0;
      abort_r = 1'b1;
      @(negedge clk);
      chk("abort_nowrite", 64'(s_write), 64'd0);
      @(posedge clk); #1;
      abort_r = 1'b0;
      @(negedge clk);
      chk("abort_idle", 64'(s_ctl), 64'd0);
      nexp = abort_k / 4;
      if (abort_k > 0 && abort_k % 4 == 0) nexp--;
    end else begin
      nexp = wc;
    end
    check_writes(nexp, sel ? BASE1 : BASE0);
  endtask

  initial begin
    int wc, ak;
    rst = 1'b1;
    start_r = 1'b0; abort_r = 1'b0; bv_r = 1'b0; wc_r = 16'd0; bd_r = 8'd0; use1 = 1'b0;
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_ctl0", 64'(ctl0), 64'd0);
    chk("rst_ctl1", 64'(ctl1), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ctl0", 64'(ctl0), 64'd0);

    // Basic two-word load; junk byte_valid while idle must be ignored.
    bv_r = 1'b1;
    bd_r = 8'hFF;
    repeat (3) @(negedge clk);
    chk("idle_no_ready", 64'(s_ready), 64'd0);
    pat = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
    run_load(2, 0, -1, 1'b0);
    run_load(2, 1, -1, 1'b0);
    pat.delete();

    // Illegal counts, then recovery from ERR.
    do_start(16'd0);
    @(negedge clk);
    chk("err_zero", 64'({s_error, s_busy}), 64'(2'b10));
    do_start(16'd1025);
    @(negedge clk);
    chk("err_big", 64'({s_error, s_busy}), 64'(2'b10));
    sent.delete();
    check_writes(0, BASE0);
    run_load(3, 2, -1, 1'b0);
    run_load(1024, 0, -1, 1'b0);

    // Aborts in LOAD (partial words) and in WRITE.
    run_load(3, 0, 6, 1'b0);
    run_load(1, 0, 2, 1'b0);
    run_load(1, 2, -1, 1'b0);
    run_load(2, 0, 4, 1'b0);

    // Reset landing on a WRITE cycle.
    use1 = 1'b0;
    sent.delete();
    do_start(16'd2);
    for (int k = 0; k < 4; k++) send_byte(8'($urandom), 1'b0);
    rst  = 1'b0;
    bv_r = 1'b0;
    #1;
    chk("rst_wr_ctl", 64'(ctl0), 64'd0);
    chk("rst_wr_bus", {bus.mem_addr, bus.mem_wdata}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    sent.delete();
    check_writes(0, BASE0);
    run_load(1, 0, -1, 1'b0);

    // Random loads with random gaps and occasional aborts.
    for (int it = 0; it < 8; it++) begin
      wc = int'($urandom_range(1, 6));
      if ($urandom_range(0, 2) == 0) ak = int'($urandom_range(0, 4 * wc - 1));
      else                           ak = -1;
      run_load(wc, 2, ak, 1'b0);
    end

    // Address wrap at the top of the address space.
    run_load(2, 0, -1, 1'b1);
    run_load(1, 2, -1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
